// File: rtl/program_loader_pkg.sv
// program_loader_pkg: shared loader state encoding and stream framing constants
package program_loader_pkg;
  typedef enum logic [2:0] {IDLE, HDR_HI, HDR_LO, DATA, CSUM, DONE, ERR} state_t;
  localparam int BYTES_PER_INSTR = 3;
  localparam int HDR_BYTES = 2;
endpackage

// File: rtl/program_loader_assembler.sv
// instr_byte_assembler: packs three MSB-first bytes into a 24-bit word, pulsing word_valid the cycle after the third
module instr_byte_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [23:0] word_out,
  output logic        word_valid
);
  localparam logic [1:0] LAST = 2'(BYTES_PER_INSTR - 1);
  logic [1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cnt <= '0;
      word_out <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_valid && cnt == LAST && !clear;
      if (clear) begin
        cnt <= '0;
        word_out <= '0;
      end else if (byte_valid) begin
        cnt <= cnt == LAST ? 2'd0 : cnt + 2'd1;
        word_out <= {word_out[15:0], byte_in};
      end
    end
endmodule

// File: rtl/program_loader.sv
// program_loader: streams a checksummed image of 24-bit instructions into imem, holding the cpu until it verifies
module program_loader
  import program_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int INSTR_WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   in_valid,
  input  logic [7:0]             in_data,
  output logic                   in_ready,
  output logic                   imem_we,
  output logic [ADDR_WIDTH-1:0]  imem_addr,
  output logic [INSTR_WIDTH-1:0] imem_wdata,
  output logic                   cpu_hold,
  output logic                   load_done,
  output logic                   load_err,
  output logic [ADDR_WIDTH:0]    words_loaded
);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_WIDTH;
  state_t state, next;
  logic [7:0] len_hi, csum;
  logic [15:0] len;
  logic [17:0] bytes_left;
  logic accept, start_ok, asm_valid;
  logic [23:0] asm_word;
  assign accept = in_valid && in_ready;
  assign start_ok = start && (state == IDLE || state == DONE || state == ERR);
  assign len = {len_hi, in_data};
  assign in_ready = state == HDR_HI || state == HDR_LO || state == DATA || state == CSUM;
  assign cpu_hold = state != DONE;
  assign load_done = state == DONE;
  assign load_err = state == ERR;
  assign imem_we = asm_valid;
  assign imem_addr = words_loaded[ADDR_WIDTH-1:0];
  assign imem_wdata = INSTR_WIDTH'(asm_word);
  instr_byte_assembler u_asm (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_ok),
    .byte_valid (accept && state == DATA),
    .byte_in    (in_data),
    .word_out   (asm_word),
    .word_valid (asm_valid)
  );
  always_comb begin
    next = state;
    case (state)
      IDLE, DONE, ERR: next = start ? HDR_HI : state;
      HDR_HI: next = accept ? HDR_LO : state;
      HDR_LO: next = !accept ? state : {1'b0, len} > DEPTH ? ERR : len == 16'd0 ? CSUM : DATA;
      DATA: next = accept && bytes_left == 18'd1 ? CSUM : state;
      CSUM: next = !accept ? state : in_data == csum ? DONE : ERR;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= next;
  // the final word's write lands one cycle after its last byte, so counting follows the write strobe
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      len_hi <= '0;
      csum <= '0;
      bytes_left <= '0;
      words_loaded <= '0;
    end else begin
      if (start_ok) begin
        csum <= '0;
        words_loaded <= '0;
      end else begin
        if (accept) csum <= csum ^ in_data;
        if (asm_valid) words_loaded <= words_loaded + (ADDR_WIDTH+1)'(1);
      end
      if (accept && state == HDR_HI) len_hi <= in_data;
      if (accept && state == HDR_LO) bytes_left <= 18'(len) * 18'(BYTES_PER_INSTR);
      else if (accept && state == DATA) bytes_left <= bytes_left - 18'd1;
    end
endmodule
